// File: rtl/freq_div_10000.sv
// freq_div_10000: divides clk by an even DIVIDE into a 50% duty, register-driven output clock
module freq_div_10000 #(
    parameter int DIVIDE = 10000,
    parameter int HALF   = DIVIDE / 2
) (
    input  logic clk,
    input  logic reset,
    output logic clk_div_10000
);
    localparam int W = HALF > 1 ? $clog2(HALF) : 1;
    localparam logic [W-1:0] LAST = W'(HALF - 1);
    logic [W-1:0] count;
    logic         wrap;
    // >= rather than == so any out-of-range value recovers on the next edge
    always_comb wrap = count >= LAST;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count         <= '0;
            clk_div_10000 <= 1'b0;
        end else begin
            count         <= wrap ? '0 : count + 1'b1;
            clk_div_10000 <= wrap ? ~clk_div_10000 : clk_div_10000;
        end
endmodule

// File: tb/tb_freq_div_10000.sv
// tb_freq_div_10000: edge-count model check of the default and DIVIDE=4 dividers
module tb_freq_div_10000;
    localparam int NS = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic out, out4;
    int passed = 0, total = 0, rises = 0, falls = 0;
    longint n = 0;
    longint tog[$];
    longint last_t = -1, last_rise = -1, rel_t = 0;

    freq_div_10000 dut (.clk(clk), .reset(reset), .clk_div_10000(out));
    freq_div_10000 #(.DIVIDE(4)) dut4 (.clk(clk), .reset(reset), .clk_div_10000(out4));

    always #NS clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0d", name, act, exp, $time);
    endtask

    // rising edges seen since the last reset release
    always @(posedge clk or negedge reset) n <= !reset ? 0 : n + 1;

    always @(negedge clk) begin
        check("out", out, reset ? (n / 5000) % 2 : 0);
        check("count", dut.count, reset ? n % 5000 : 0);
        check("count_range", dut.count <= 4999, 1);
        check("out4", out4, reset ? (n / 2) % 2 : 0);
        check("count4", dut4.count, reset ? n % 2 : 0);
    end

    always @(out) begin
        if (!reset) last_t = -1;
        else begin
            if (last_t >= 0) check("interval_cycles", ($time - last_t) / (2 * NS), 5000);
            last_t = $time;
            tog.push_back($time / NS);
            if (out) begin
                rises++;
                last_rise = $time;
            end else falls++;
        end
    end

    initial begin
        #(5 * NS);
        check("pwr_out", out, 0);
        check("pwr_count", dut.count, 0);
        #(5 * NS);
        reset = 1'b1;
        #(2 * NS) check("div4_edge1", out4, 0);
        #(2 * NS) check("div4_edge2", out4, 1);
        #(2 * NS) check("div4_edge3", out4, 1);
        #(2 * NS) check("div4_edge4", out4, 0);
        #((100010 - 18) * NS);
        check("rises_100us", rises, 5);
        check("falls_100us", falls, 5);
        check("rise1_ns", tog[0], 10009);
        check("fall1_ns", tog[1], 20009);
        check("rise2_ns", tog[2], 30009);
        for (int i = 0; i < 20000 && n != 57500; i++) @(negedge clk);
        check("mid_n", n, 57500);
        check("mid_out", out, 1);
        check("mid_count", dut.count, 2500);
        #3 reset = 1'b0;
        #3;
        check("async_out", out, 0);
        check("async_count", dut.count, 0);
        check("async_out4", out4, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        rel_t = $time;
        #(10005 * NS);
        check("restart_rise", last_rise, rel_t + (NS - 2) + 4999 * 2 * NS);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
